// File: rtl/sync_fifo_pkg.sv
// Shared level/flag helpers for the sync_fifo family (single-clock now, async variants later).
package sync_fifo_pkg;

   // Wide enough for DEPTH_WIDTH up to 20 plus the wrap bit.
   localparam int unsigned LEVEL_MAX_W = 21;

   typedef logic [LEVEL_MAX_W-1:0] fifo_level_t;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic empty;
      logic almost_empty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, almost_full: 1'b0,
                                         empty: 1'b1, almost_empty: 1'b1};

   function automatic int unsigned level_width(int unsigned depth_width);
      return depth_width + 1;
   endfunction

   function automatic fifo_flags_t fifo_flags(fifo_level_t level, fifo_level_t depth,
                                              fifo_level_t af_num, fifo_level_t ae_num);
      fifo_flags_t f;
      f.full         = (level == depth);
      f.almost_full  = (level >= af_num);
      f.empty        = (level == '0);
      f.almost_empty = (level <= ae_num);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_wl_if.sv
// Handshake bundle for sync_fifo_wl; overflow/underflow exist only with SYNC_FIFO_ERR_FLAG_EN.
interface sync_fifo_wl_if #(
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned DEPTH_WIDTH = 11
);
   logic                   flush;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   wr_en;
   logic                   full;
   logic                   almost_full;
   logic                   rd_en;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   rd_valid;
   logic                   empty;
   logic                   almost_empty;
   logic [DEPTH_WIDTH:0]   water_level;
`ifdef SYNC_FIFO_ERR_FLAG_EN
   logic                   overflow;
   logic                   underflow;
`endif

   modport master (
`ifdef SYNC_FIFO_ERR_FLAG_EN
      input  overflow, underflow,
`endif
      output flush, wr_data, wr_en, rd_en,
      input  full, almost_full, rd_data, rd_valid, empty, almost_empty, water_level
   );

   modport slave (
`ifdef SYNC_FIFO_ERR_FLAG_EN
      output overflow, underflow,
`endif
      input  flush, wr_data, wr_en, rd_en,
      output full, almost_full, rd_data, rd_valid, empty, almost_empty, water_level
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port memory: one write port, registered read port, optional second read register.
module sync_fifo_ram #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned OUTPUT_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_s1_q;
   logic                  valid_s1_q;

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // rd_en is already qualified by flush upstream, so valid_s1 clears on flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_s1_q <= '0;
         valid_s1_q <= 1'b0;
      end else begin
         valid_s1_q <= rd_en;
         if (rd_en) begin
            rdata_s1_q <= mem[rd_addr];
         end
      end
   end

   if (OUTPUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rdata_s2_q;
      logic                  valid_s2_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rdata_s2_q <= '0;
            valid_s2_q <= 1'b0;
         end else begin
            valid_s2_q <= valid_s1_q & ~flush;
            if (valid_s1_q && !flush) begin
               rdata_s2_q <= rdata_s1_q;
            end
         end
      end

      assign rd_data  = rdata_s2_q;
      assign rd_valid = valid_s2_q;
   end else begin : g_no_out_reg
      assign rd_data  = rdata_s1_q;
      assign rd_valid = valid_s1_q;
   end

endmodule

// File: rtl/sync_fifo_wl.sv
// Single-clock FIFO with registered flags, water level and programmable thresholds.
// Optional sticky overflow/underflow outputs under SYNC_FIFO_ERR_FLAG_EN.
module sync_fifo_wl
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 4,
   parameter int unsigned DEPTH_WIDTH      = 11,
   parameter int unsigned ALMOST_FULL_NUM  = 2044,
   parameter int unsigned ALMOST_EMPTY_NUM = 4,
   parameter int unsigned OUTPUT_REG       = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   sync_fifo_wl_if.slave  bus
);

   localparam int unsigned LW    = level_width(DEPTH_WIDTH);
   localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;

   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   fifo_flags_t   flags_q, flags_d;
   logic          wr_acc, rd_acc;

   assign wr_acc = bus.wr_en & ~flags_q.full  & ~bus.flush;
   assign rd_acc = bus.rd_en & ~flags_q.empty & ~bus.flush;

   // Level comes from the pointer difference; the MSB carries the wrap state.
   always_comb begin
      wr_ptr_d = wr_ptr_q + LW'(wr_acc);
      rd_ptr_d = rd_ptr_q + LW'(rd_acc);
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
      level_d = wr_ptr_d - rd_ptr_d;
      flags_d = fifo_flags(fifo_level_t'(level_d), fifo_level_t'(DEPTH),
                           fifo_level_t'(ALMOST_FULL_NUM), fifo_level_t'(ALMOST_EMPTY_NUM));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         flags_q  <= FLAGS_RST;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         flags_q  <= flags_d;
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_WIDTH),
      .OUTPUT_REG (OUTPUT_REG)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .wr_en    (wr_acc),
      .wr_addr  (wr_ptr_q[DEPTH_WIDTH-1:0]),
      .wr_data  (bus.wr_data),
      .rd_en    (rd_acc),
      .rd_addr  (rd_ptr_q[DEPTH_WIDTH-1:0]),
      .rd_data  (bus.rd_data),
      .rd_valid (bus.rd_valid)
   );

   assign bus.full         = flags_q.full;
   assign bus.almost_full  = flags_q.almost_full;
   assign bus.empty        = flags_q.empty;
   assign bus.almost_empty = flags_q.almost_empty;
   assign bus.water_level  = level_q;

`ifdef SYNC_FIFO_ERR_FLAG_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.flush) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr_en && flags_q.full) begin
            overflow_q <= 1'b1;
         end
         if (bus.rd_en && flags_q.empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule
